// File: rtl/tetris_input_pkg.sv
// Shared action enum, HID keycodes and FSM state type for the key auto-repeat block.
package tetris_input_pkg;

  localparam int NUM_ACTIONS = 6;

  typedef enum logic [2:0] {
    ACT_LEFT      = 3'd0,
    ACT_RIGHT     = 3'd1,
    ACT_SOFT_DROP = 3'd2,
    ACT_ROT_CW    = 3'd3,
    ACT_ROT_CCW   = 3'd4,
    ACT_HARD_DROP = 3'd5
  } action_e;

  localparam logic [7:0] HID_LEFT      = 8'h50;
  localparam logic [7:0] HID_RIGHT     = 8'h4F;
  localparam logic [7:0] HID_SOFT_DROP = 8'h51;
  localparam logic [7:0] HID_ROT_CW    = 8'h52;
  localparam logic [7:0] HID_ROT_CCW   = 8'h1D;
  localparam logic [7:0] HID_HARD_DROP = 8'h2C;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DELAY  = 2'd1,
    ST_REPEAT = 2'd2
  } rep_state_e;

  function automatic logic [7:0] action_code(input action_e a);
    case (a)
      ACT_LEFT:      return HID_LEFT;
      ACT_RIGHT:     return HID_RIGHT;
      ACT_SOFT_DROP: return HID_SOFT_DROP;
      ACT_ROT_CW:    return HID_ROT_CW;
      ACT_ROT_CCW:   return HID_ROT_CCW;
      ACT_HARD_DROP: return HID_HARD_DROP;
      default:       return 8'h00;
    endcase
  endfunction

  // Movement keys repeat; rotations and hard drop fire once per press.
  function automatic bit action_repeatable(input action_e a);
    return (a == ACT_LEFT) || (a == ACT_RIGHT) || (a == ACT_SOFT_DROP);
  endfunction

endpackage

// File: rtl/key_repeat_fsm.sv
// Per-action IDLE/DELAY/REPEAT controller with registered one-clk pulse.
// DAS/ARR counting exists only when KEY_REPEAT_ARR_EN is defined.
module key_repeat_fsm
  import tetris_input_pkg::*;
#(
  parameter bit REPEATABLE = 1'b0,
  parameter int DAS_FRAMES = 16,
  parameter int ARR_FRAMES = 4,
  parameter int CNT_W      = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic frame_tick,
  input  logic present,
  input  logic suppress,
  output logic pulse
);

  if (DAS_FRAMES < 2 || DAS_FRAMES > 255) begin : g_bad_das
    $error("key_repeat_fsm: DAS_FRAMES must be 2..255");
  end
  if (ARR_FRAMES < 1 || ARR_FRAMES > 255) begin : g_bad_arr
    $error("key_repeat_fsm: ARR_FRAMES must be 1..255");
  end
  if (REPEATABLE && (CNT_W < $clog2(DAS_FRAMES) || CNT_W < $clog2(ARR_FRAMES))) begin : g_bad_cnt
    $error("key_repeat_fsm: CNT_W too narrow for DAS/ARR");
  end

  rep_state_e state_q, state_d;
  logic       pulse_q, pulse_d;

`ifdef KEY_REPEAT_ARR_EN
  localparam logic [CNT_W-1:0] DAS_LAST = CNT_W'(DAS_FRAMES - 1);
  localparam logic [CNT_W-1:0] ARR_LAST = CNT_W'(ARR_FRAMES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction
`endif

  always_comb begin
    state_d = state_q;
    pulse_d = 1'b0;
`ifdef KEY_REPEAT_ARR_EN
    cnt_d   = cnt_q;
`endif
    if (frame_tick) begin
      if (!present) begin
        state_d = ST_IDLE;
`ifdef KEY_REPEAT_ARR_EN
        cnt_d   = '0;
`endif
      end else begin
        case (state_q)
          ST_IDLE: begin
            state_d = ST_DELAY;
            pulse_d = ~suppress;
`ifdef KEY_REPEAT_ARR_EN
            cnt_d   = '0;
`endif
          end
          ST_DELAY: begin
`ifdef KEY_REPEAT_ARR_EN
            // Compare before incrementing so the first repeat lands DAS_FRAMES ticks after the press.
            if (REPEATABLE) begin
              if (cnt_q == DAS_LAST) begin
                state_d = ST_REPEAT;
                cnt_d   = '0;
                pulse_d = ~suppress;
              end else begin
                cnt_d = sat_inc(cnt_q);
              end
            end
`else
            state_d = ST_DELAY;
`endif
          end
          ST_REPEAT: begin
`ifdef KEY_REPEAT_ARR_EN
            if (cnt_q == ARR_LAST) begin
              cnt_d   = '0;
              pulse_d = ~suppress;
            end else begin
              cnt_d = sat_inc(cnt_q);
            end
`else
            state_d = ST_DELAY;
`endif
          end
          default: state_d = ST_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      pulse_q <= 1'b0;
`ifdef KEY_REPEAT_ARR_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      pulse_q <= pulse_d;
`ifdef KEY_REPEAT_ARR_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign pulse = pulse_q;

endmodule

// File: rtl/key_repeat_ctrl.sv
// HID keycode sampler driving six action FSMs; auto-repeat enabled by KEY_REPEAT_ARR_EN.
// Keycodes are only observed on frame_tick; outputs are registered.
module key_repeat_ctrl
  import tetris_input_pkg::*;
#(
  parameter int NUM_SLOTS  = 4,
  parameter int DAS_FRAMES = 16,
  parameter int ARR_FRAMES = 4,
  parameter int CNT_W      = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   frame_tick,
  input  logic [8*NUM_SLOTS-1:0] keycodes,
  output logic [5:0]             action_pulse,
  output logic [5:0]             action_held
);

  if (NUM_SLOTS < 1) begin : g_bad_slots
    $error("key_repeat_ctrl: NUM_SLOTS must be at least 1");
  end

  logic [NUM_ACTIONS-1:0] present;
  logic [NUM_ACTIONS-1:0] suppress;
  logic [NUM_ACTIONS-1:0] held_q, held_d;
  logic                   lr_conflict;

  for (genvar a = 0; a < NUM_ACTIONS; a++) begin : g_act
    localparam logic [7:0] CODE = action_code(action_e'(a));
    logic [NUM_SLOTS-1:0]  slot_hit;

    // Duplicate slots simply OR together; a zero code would match empty slots, so it is masked.
    for (genvar s = 0; s < NUM_SLOTS; s++) begin : g_slot
      assign slot_hit[s] = (keycodes[8*s +: 8] == CODE);
    end
    assign present[a] = (CODE != 8'h00) && (|slot_hit);

    key_repeat_fsm #(
      .REPEATABLE (action_repeatable(action_e'(a))),
      .DAS_FRAMES (DAS_FRAMES),
      .ARR_FRAMES (ARR_FRAMES),
      .CNT_W      (CNT_W)
    ) u_fsm (
      .clk        (clk),
      .reset      (reset),
      .frame_tick (frame_tick),
      .present    (present[a]),
      .suppress   (suppress[a]),
      .pulse      (action_pulse[a])
    );
  end

  // Opposing directions cancel each other's pulses but both FSMs keep counting.
  always_comb begin
    lr_conflict = present[ACT_LEFT] & present[ACT_RIGHT];
    suppress    = '0;
    suppress[ACT_LEFT]  = lr_conflict;
    suppress[ACT_RIGHT] = lr_conflict;
  end

  always_comb begin
    held_d = held_q;
    if (frame_tick) begin
      held_d = present;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      held_q <= '0;
    end else begin
      held_q <= held_d;
    end
  end

  assign action_held = held_q;

endmodule

// File: tb/tb_key_repeat_ctrl.sv
// Directed bench for key_repeat_ctrl; expectations follow KEY_REPEAT_ARR_EN.
module tb_key_repeat_ctrl;
  import tetris_input_pkg::*;

  localparam int NS = 4;
`ifdef KEY_REPEAT_ARR_EN
  localparam bit ARR = 1'b1;
`else
  localparam bit ARR = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            frame_tick = 1'b0;
  logic [8*NS-1:0] keycodes = '0;
  logic [5:0]      action_pulse;
  logic [5:0]      action_held;

  int         checks = 0;
  int         errors = 0;
  int         pcnt [6];
  logic [5:0] p_last;
  logic [5:0] h_last;
  logic [31:0] mask;
  int          bad;
  logic [5:0]  held_or;

  key_repeat_ctrl #(
    .NUM_SLOTS  (NS),
    .DAS_FRAMES (16),
    .ARR_FRAMES (4),
    .CNT_W      (8)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .frame_tick   (frame_tick),
    .keycodes     (keycodes),
    .action_pulse (action_pulse),
    .action_held  (action_held)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    for (int a = 0; a < 6; a++) pcnt[a] = 0;
  endtask

  task automatic tick();
    @(negedge clk) frame_tick = 1'b1;
    @(negedge clk) frame_tick = 1'b0;
    p_last = action_pulse;
    h_last = action_held;
    for (int a = 0; a < 6; a++) if (action_pulse[a]) pcnt[a]++;
  endtask

  task automatic release_all();
    keycodes = '0;
    tick();
    tick();
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    chk("reset_pulse", {26'd0, action_pulse}, 32'd0);
    chk("reset_held",  {26'd0, action_held},  32'd0);
    reset = 1'b0;
    @(negedge clk);

    // LEFT in slot 2 for 30 ticks
    clr();
    mask = '0;
    bad  = 0;
    keycodes = 32'h0050_0000;
    for (int t = 0; t < 30; t++) begin
      tick();
      if (p_last[ACT_LEFT]) mask[t] = 1'b1;
      if (!h_last[ACT_LEFT]) bad++;
      if (t == 0) begin
        @(negedge clk);
        chk("left_pulse_one_clk", {26'd0, action_pulse}, 32'd0);
      end
    end
    chk("left_pulse_ticks", mask, ARR ? 32'h1111_0001 : 32'h0000_0001);
    chk("left_pulse_count", pcnt[ACT_LEFT], ARR ? 32'd5 : 32'd1);
    chk("left_held_30", bad, 32'd0);
    chk("left_others_quiet", pcnt[1] + pcnt[2] + pcnt[3] + pcnt[4] + pcnt[5], 32'd0);
    keycodes = '0;
    tick();
    chk("left_release_held", {26'd0, h_last}, 32'd0);
    chk("left_release_pulse", {26'd0, p_last}, 32'd0);
    tick();

    // Keycodes between ticks are ignored; held level persists
    keycodes = 32'h0000_0050;
    tick();
    chk("sample_held_set", {26'd0, h_last}, 32'h01);
    keycodes = 32'h0000_0052;
    repeat (5) @(negedge clk);
    chk("sample_held_keep", {26'd0, action_held}, 32'h01);
    chk("sample_no_pulse", {26'd0, action_pulse}, 32'd0);
    keycodes = '0;
    tick();
    chk("sample_held_clear", {26'd0, h_last}, 32'd0);

    // Toggle only between ticks
    clr();
    held_or = '0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk) keycodes = 32'h2C1D_5251;
      @(negedge clk) keycodes = 32'h4F50_0000;
      @(negedge clk) keycodes = '0;
      tick();
      held_or |= h_last;
    end
    chk("toggle_pulses", pcnt[0] + pcnt[1] + pcnt[2] + pcnt[3] + pcnt[4] + pcnt[5], 32'd0);
    chk("toggle_held", {26'd0, held_or}, 32'd0);

    // ROT_CW: hold 40, release 1, hold again
    clr();
    keycodes = 32'h0000_0052;
    repeat (40) tick();
    keycodes = '0;
    tick();
    chk("rotcw_release_held", {31'd0, h_last[ACT_ROT_CW]}, 32'd0);
    keycodes = 32'h0000_0052;
    repeat (5) tick();
    chk("rotcw_pulse_count", pcnt[ACT_ROT_CW], 32'd2);
    release_all();

    // HARD_DROP in every slot counts as one press
    clr();
    keycodes = 32'h2C2C_2C2C;
    repeat (6) tick();
    chk("hdrop_dup_count", pcnt[ACT_HARD_DROP], 32'd1);
    chk("hdrop_dup_held", {26'd0, h_last}, 32'h20);
    release_all();

    // LEFT + RIGHT together, then RIGHT released
    clr();
    keycodes = 32'h0000_4F50;
    repeat (20) tick();
    chk("lr_both_pulses", pcnt[ACT_LEFT] + pcnt[ACT_RIGHT], 32'd0);
    chk("lr_both_held", {26'd0, h_last}, 32'h03);
    keycodes = 32'h0000_0050;
    tick();
    chk("lr_after_release", {26'd0, p_last}, ARR ? 32'h01 : 32'h00);
    repeat (4) tick();
    chk("lr_left_total", pcnt[ACT_LEFT], ARR ? 32'd2 : 32'd0);
    chk("lr_right_total", pcnt[ACT_RIGHT], 32'd0);
    release_all();

    // Reset mid-repeat on SOFT_DROP
    clr();
    keycodes = 32'h0000_0051;
    repeat (17) tick();
    chk("sd_repeat_entry", {31'd0, p_last[ACT_SOFT_DROP]}, ARR ? 32'd1 : 32'd0);
    #2 reset = 1'b1;
    #1;
    chk("sd_reset_pulse", {26'd0, action_pulse}, 32'd0);
    chk("sd_reset_held",  {26'd0, action_held},  32'd0);
    @(negedge clk) frame_tick = 1'b1;
    @(negedge clk) frame_tick = 1'b0;
    chk("sd_reset_tick_ignored", {20'd0, action_pulse, action_held}, 32'd0);
    @(negedge clk) reset = 1'b0;
    tick();
    chk("sd_after_reset_pulse", {26'd0, p_last}, 32'h04);
    chk("sd_after_reset_held",  {26'd0, h_last}, 32'h04);
    release_all();

    // RIGHT held for 50 ticks
    clr();
    keycodes = 32'h0000_004F;
    repeat (50) tick();
    chk("right50_count", pcnt[ACT_RIGHT], ARR ? 32'd10 : 32'd1);
    chk("right50_others", pcnt[0] + pcnt[2] + pcnt[3] + pcnt[4] + pcnt[5], 32'd0);
    release_all();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/key_repeat_ctrl.md
KEY_REPEAT_CTRL -- requirements
Module: key_repeat_ctrl

Interface
REQ-001 SHALL have parameter NUM_SLOTS, default 4: number of 8-bit HID keycode slots sampled.
REQ-002 SHALL have parameter DAS_FRAMES, default 16: frames a key is held before auto-repeat starts (legal 2..255).
REQ-003 SHALL have parameter ARR_FRAMES, default 4: frames between auto-repeat pulses (legal 1..255).
REQ-004 SHALL have parameter CNT_W, default 8: width of each per-action frame counter.
REQ-005 Port list SHALL be exactly the following, with one clock; reset is asynchronous and active-high (named clk and reset).
REQ-006 clk  input  1  system clock.
REQ-007 reset  input  1  asynchronous active-high reset.
REQ-008 frame_tick  input  1  one-clk pulse per video frame, already synchronous to clk.
REQ-009 keycodes  input  8*NUM_SLOTS  packed HID keycodes; slot 0 = bits [7:0].
REQ-010 action_pulse  output  6  one-clk pulse per action event, index = action enum.
REQ-011 action_held  output  6  level; action's key present in the latest sampled frame.

Function
REQ-012 Actions and codes, in index order: LEFT 0x50, RIGHT 0x4F, SOFT_DROP 0x51, ROT_CW 0x52, ROT_CCW 0x1D, HARD_DROP 0x2C.
REQ-013 keycodes SHALL be sampled only on cycles with frame_tick=1; between ticks, changes on keycodes SHALL be ignored.
REQ-014 An action is present when any slot equals its code; code 0x00 matches nothing; duplicate slots count as one press.
REQ-015 Each action SHALL run an FSM with states IDLE, DELAY and REPEAT; it updates only on frame_tick.
REQ-016 IDLE + present -> DELAY, counter=0, pulse asserted.
REQ-017 DELAY + present -> counter+1; on reaching DAS_FRAMES-1 -> REPEAT, counter=0, pulse asserted.
REQ-018 REPEAT + present -> counter+1; on reaching ARR_FRAMES-1 -> counter=0, pulse asserted.
REQ-019 Any state + absent -> IDLE, counter=0, no pulse.
REQ-020 Only LEFT, RIGHT and SOFT_DROP SHALL auto-repeat; ROT_CW, ROT_CCW and HARD_DROP stay in DELAY while held and pulse once per press.
REQ-021 When LEFT and RIGHT are both present in the same sample, both pulses SHALL be suppressed; their FSMs still advance.
REQ-022 action_pulse SHALL assert exactly one clk, in the cycle after the frame_tick that causes it (latency 1), and is registered.
REQ-023 action_held SHALL update in the cycle after each frame_tick and hold until the next tick.
REQ-024 Counters SHALL saturate rather than wrap; no action ever pulses more than once per frame.

Reset
REQ-025 Reset SHALL force all FSMs to IDLE, all counters to 0, and action_pulse and action_held to 0, asynchronously, including mid-repeat.
REQ-026 A key held through reset deassertion SHALL be treated as a new press at the first frame_tick after reset.

Configuration
REQ-027 With macro KEY_REPEAT_ARR_EN defined, REQ-017/018 auto-repeat SHALL be active for repeatable actions.
REQ-028 Without KEY_REPEAT_ARR_EN, every action SHALL behave as one-shot per REQ-020, and the DAS/ARR counters SHALL not be synthesised.

Structure
REQ-029 Package tetris_input_pkg SHALL hold the action enum (6 entries), the HID code constants and the FSM state typedef.
REQ-030 The per-action FSM plus counter SHALL be the sub-module key_repeat_fsm, instantiated 6 times with a REPEATABLE parameter.

Verification
REQ-031 Hold 0x50 in slot 2 for 30 ticks with defaults -> LEFT pulses at ticks 1, 17, 21, 25 and 29 (5 pulses); action_held[LEFT]=1 throughout.
REQ-032 Hold 0x52 for 40 ticks, release 1 tick, hold again -> exactly 2 ROT_CW pulses.
REQ-033 Hold 0x50 and 0x4F together for 20 ticks -> zero LEFT/RIGHT pulses; release 0x4F -> next LEFT pulse per the ongoing FSM count.
REQ-034 Toggle keycodes between ticks only, with stable 0x00 at tick edges -> no pulses, action_held=0.
REQ-035 Assert reset mid-REPEAT on SOFT_DROP with 0x51 still held -> outputs 0 immediately; pulse at the first tick after release of reset.
REQ-036 Build without KEY_REPEAT_ARR_EN and hold 0x4F for 50 ticks -> exactly 1 RIGHT pulse.
